// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision adder between two requesters.
// Operands and result are registered around the adder; each requester has its own response channel.

module fp_add_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  symbol,
  output logic [DATA_WIDTH-1:0] out
);

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd27;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic        sb, eff_add, swap, s_big;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic [30:0] mag_big, mag_small;
  logic [9:0]  e_big, e_small, e_eff, sh, exp_out;
  logic [23:0] m_big, m_small;
  logic [7:0]  diff;
  logic [26:0] small_ext, aligned, norm;
  logic        sticky, round_up, hidden;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic [24:0] rnd;
  logic [22:0] frac;

  always_comb begin
    sb      = b[31] ^ symbol;
    eff_add = (a[31] == sb);
    a_nan   = (&a[30:23]) & (|a[22:0]);
    b_nan   = (&b[30:23]) & (|b[22:0]);
    a_inf   = (&a[30:23]) & ~(|a[22:0]);
    b_inf   = (&b[30:23]) & ~(|b[22:0]);

    swap      = b[30:0] > a[30:0];
    mag_big   = swap ? b[30:0] : a[30:0];
    mag_small = swap ? a[30:0] : b[30:0];
    s_big     = swap ? sb : a[31];

    // Subnormals use exponent 1 with no hidden bit.
    e_big   = (mag_big[30:23] == 8'd0) ? 10'd1 : {2'b00, mag_big[30:23]};
    e_small = (mag_small[30:23] == 8'd0) ? 10'd1 : {2'b00, mag_small[30:23]};
    m_big   = {|mag_big[30:23], mag_big[22:0]};
    m_small = {|mag_small[30:23], mag_small[22:0]};
    diff    = 8'(e_big - e_small);

    small_ext = {m_small, 3'b000};
    if (diff >= 8'd27) begin
      aligned = '0;
      sticky  = |m_small;
    end else begin
      aligned = small_ext >> diff;
      sticky  = |(small_ext & ((27'd1 << diff) - 27'd1));
    end
    aligned[0] = aligned[0] | sticky;

    sum = eff_add ? ({1'b0, m_big, 3'b000} + {1'b0, aligned})
                  : ({1'b0, m_big, 3'b000} - {1'b0, aligned});

    // Left shift is limited so the result can land in the subnormal range.
    lz = lzc27(sum[26:0]);
    sh = ({5'b0, lz} < e_big) ? {5'b0, lz} : e_big - 10'd1;
    if (sum[27]) begin
      norm  = {sum[27:2], sum[1] | sum[0]};
      e_eff = e_big + 10'd1;
    end else begin
      norm  = sum[26:0] << sh;
      e_eff = e_big - sh;
    end

    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
    if (rnd[24]) begin
      e_eff  = e_eff + 10'd1;
      frac   = rnd[23:1];
      hidden = 1'b1;
    end else begin
      frac   = rnd[22:0];
      hidden = rnd[23];
    end
    exp_out = hidden ? e_eff : 10'd0;

    if (a_nan | b_nan | (a_inf & b_inf & ~eff_add))
      out = 32'h7FC0_0000;
    else if (a_inf)
      out = a;
    else if (b_inf)
      out = {sb, b[30:0]};
    else if (sum == 28'd0)
      out = {eff_add & a[31], 31'd0};
    else if (exp_out >= 10'd255)
      out = {s_big, 8'hFF, 23'd0};
    else
      out = {s_big, exp_out[7:0], frac};
  end

endmodule

// state | meaning
// IDLE  | arbitrate; pulse ready to the winner and capture its operands
// EXEC  | adder works on the op registers; result captured on exit
// RESP  | result offered on the winner's channel until it is consumed
module fp_add_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req0_symbol,
  output logic                  rsp0_valid,
  input  logic                  rsp0_ready,
  output logic [DATA_WIDTH-1:0] rsp0_out,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  input  logic                  req1_symbol,
  output logic                  rsp1_valid,
  input  logic                  rsp1_ready,
  output logic [DATA_WIDTH-1:0] rsp1_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  grant_id_q, grant_id_d;
  logic [DATA_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic                  op_sym_q, op_sym_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] add_out;
  logic                  grant0, grant1;

  fp_add_unit #(.DATA_WIDTH(DATA_WIDTH)) u_add (
    .a      (op_a_q),
    .b      (op_b_q),
    .symbol (op_sym_q),
    .out    (add_out)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sym_d     = op_sym_q;
    result_d     = result_q;
    grant0       = 1'b0;
    grant1       = 1'b0;
    case (state_q)
      IDLE: begin
        grant0 = req0_valid & (~req1_valid | last_grant_q);
        grant1 = req1_valid & (~req0_valid | ~last_grant_q);
        if (grant0 | grant1) begin
          op_a_d       = grant1 ? req1_a : req0_a;
          op_b_d       = grant1 ? req1_b : req0_b;
          op_sym_d     = grant1 ? req1_symbol : req0_symbol;
          grant_id_d   = grant1;
          last_grant_d = grant1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        result_d = add_out;
        state_d  = RESP;
      end
      RESP: begin
        if (grant_id_q ? rsp1_ready : rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sym_q     <= 1'b0;
      result_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sym_q     <= op_sym_d;
      result_q     <= result_d;
    end
  end

  // Ready is gated by rst so every output is low while reset is held.
  assign req0_ready = grant0 & ~rst;
  assign req1_ready = grant1 & ~rst;
  assign rsp0_valid = (state_q == RESP) & ~grant_id_q;
  assign rsp1_valid = (state_q == RESP) & grant_id_q;
  assign rsp0_out   = grant_id_q ? '0 : result_q;
  assign rsp1_out   = grant_id_q ? result_q : '0;
  assign busy       = (state_q != IDLE);

endmodule
